nco_poly: RTL and testbench

NCO_POLY -- requirements
Module: nco_poly

---
 rtl/nco_poly.sv | 189 ++++++++++++++++++
 tb/tb_nco_poly.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/nco_poly.sv
`default_nettype none
// ============================================================================
// nco_poly : polyphonic sine NCO, one LUT path time-shared across all voices.
// Define NCO_INTERP_EN for linear LUT interpolation (one extra cycle per sweep).
// Revision 1.0
// ============================================================================
module nco_poly #(
   parameter int N_VOICES = 4,
   parameter int PHASE_W  = 24,
   parameter int LUT_AW   = 8,
   parameter int CODE_W   = 10
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          fcw_wr_en,
   input  logic [((N_VOICES > 1) ? $clog2(N_VOICES) : 1)-1:0] fcw_wr_idx,
   input  logic [PHASE_W-1:0]                            fcw_wr_data,
   input  logic [N_VOICES-1:0]                           voice_en,
   input  logic                                          next_sample,
   output logic                                          busy,
   output logic [CODE_W-1:0]                             code,
   output logic                                          code_valid
);

   localparam int c_idx_w = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
   localparam int c_sel_w = $clog2(N_VOICES);
   localparam int c_acc_w = CODE_W + c_sel_w;
   localparam int c_cnt_w = c_idx_w + 1;
   localparam int c_lut_n = 2 ** LUT_AW;
`ifdef NCO_INTERP_EN
   localparam int c_last  = N_VOICES;
`else
   localparam int c_last  = N_VOICES - 1;
`endif
   localparam logic [CODE_W-1:0]        c_mid   = CODE_W'(2 ** (CODE_W - 1));
   localparam logic signed [CODE_W+1:0] c_mid_s = (CODE_W + 2)'(2 ** (CODE_W - 1));

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_OUT   = 2'd2
   } state_t;

   // Elaboration-time sine: fold to the first quadrant, Taylor series there.
   function automatic logic [CODE_W-1:0] lut_entry(input int k);
      real x;
      real term;
      real s;
      int  kk;
      int  m;
      bit  neg;
      neg = (k >= c_lut_n / 2);
      kk  = neg ? k - c_lut_n / 2 : k;
      if (kk > c_lut_n / 4) kk = c_lut_n / 2 - kk;
      if (kk == c_lut_n / 4) begin
         m = 2 ** (CODE_W - 1) - 1;
      end else begin
         x    = 2.0 * 3.14159265358979323846 * $itor(kk) / $itor(c_lut_n);
         term = x;
         s    = x;
         for (int i = 1; i < 12; i++) begin
            term = -term * x * x / $itor((2 * i) * (2 * i + 1));
            s    = s + term;
         end
         m = $rtoi($itor(2 ** (CODE_W - 1) - 1) * s);
      end
      lut_entry = neg ? CODE_W'(2 ** (CODE_W - 1) - m) : CODE_W'(2 ** (CODE_W - 1) + m);
   endfunction

   logic [CODE_W-1:0] w_lut [c_lut_n];
   for (genvar k = 0; k < c_lut_n; k++) begin : g_lut
      localparam logic [CODE_W-1:0] c_val = lut_entry(k);
      assign w_lut[k] = c_val;
   end

   state_t                     r_state;
   logic [c_cnt_w-1:0]         r_idx;
   logic [N_VOICES-1:0]        r_en;
   logic [PHASE_W-1:0]         r_phase [N_VOICES];
   logic [PHASE_W-1:0]         r_fcw   [N_VOICES];
   logic signed [c_acc_w-1:0]  r_acc;
   logic                       r_busy;
   logic [CODE_W-1:0]          r_code;
   logic                       r_code_valid;

   logic [c_idx_w-1:0]         w_vidx;
   logic                       w_proc;
   logic [PHASE_W-1:0]         w_phase_new;
   logic [LUT_AW-1:0]          w_addr;
   logic signed [CODE_W+1:0]   w_val;
   logic signed [CODE_W+1:0]   w_contrib;

   assign w_vidx      = r_idx[c_idx_w-1:0];
   assign w_proc      = (r_state == S_SWEEP) && (r_idx < c_cnt_w'(N_VOICES));
   assign w_phase_new = r_phase[w_vidx] + r_fcw[w_vidx];
   assign w_addr      = w_phase_new[PHASE_W-1 -: LUT_AW];

`ifdef NCO_INTERP_EN
   logic [LUT_AW-1:0]          w_addr1;
   logic [3:0]                 w_frac;
   logic signed [CODE_W+1:0]   w_diff;
   logic signed [CODE_W+6:0]   w_prod;
   logic signed [CODE_W+1:0]   r_pipe;
   logic                       r_pipe_vld;

   // Second read port sits one entry ahead, wrapping at the table end.
   assign w_addr1 = w_addr + 1'b1;
   assign w_frac  = w_phase_new[PHASE_W-LUT_AW-1 -: 4];
   assign w_diff  = $signed({2'b00, w_lut[w_addr1]}) - $signed({2'b00, w_lut[w_addr]});
   assign w_prod  = w_diff * $signed({1'b0, w_frac});
   assign w_val   = $signed({2'b00, w_lut[w_addr]}) + (CODE_W + 2)'(w_prod >>> 4);
`else
   assign w_val   = $signed({2'b00, w_lut[w_addr]});
`endif

   assign w_contrib = r_en[w_vidx] ? (w_val - c_mid_s) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_en         <= '0;
         r_acc        <= '0;
         r_busy       <= 1'b0;
         r_code       <= c_mid;
         r_code_valid <= 1'b0;
         for (int v = 0; v < N_VOICES; v++) begin
            r_phase[v] <= '0;
            r_fcw[v]   <= '0;
         end
`ifdef NCO_INTERP_EN
         r_pipe       <= '0;
         r_pipe_vld   <= 1'b0;
`endif
      end else begin
         r_code_valid <= 1'b0;
         if (fcw_wr_en && (32'(fcw_wr_idx) < N_VOICES)) begin
            r_fcw[fcw_wr_idx] <= fcw_wr_data;
         end
         case (r_state)
            S_IDLE: begin
               if (next_sample) begin
                  r_state <= S_SWEEP;
                  r_busy  <= 1'b1;
                  r_idx   <= '0;
                  r_en    <= voice_en;
                  r_acc   <= '0;
`ifdef NCO_INTERP_EN
                  r_pipe_vld <= 1'b0;
`endif
               end
            end
            S_SWEEP: begin
               if (w_proc && r_en[w_vidx]) begin
                  r_phase[w_vidx] <= w_phase_new;
               end
`ifdef NCO_INTERP_EN
               r_pipe     <= w_contrib;
               r_pipe_vld <= w_proc;
               if (r_pipe_vld) r_acc <= r_acc + c_acc_w'(r_pipe);
`else
               if (w_proc) r_acc <= r_acc + c_acc_w'(w_contrib);
`endif
               if (r_idx == c_cnt_w'(c_last)) begin
                  r_state <= S_OUT;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            S_OUT: begin
               r_code       <= c_mid + CODE_W'(r_acc >>> c_sel_w);
               r_code_valid <= 1'b1;
               r_busy       <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign code       = r_code;
   assign code_valid = r_code_valid;

endmodule
`default_nettype wire

// File: tb/tb_nco_poly.sv
`default_nettype none
// tb_nco_poly : directed self-checking bench for nco_poly (default 4-voice and a 1-voice instance).
module tb_nco_poly;
   localparam int c_nv = 4;
`ifdef NCO_INTERP_EN
   localparam int c_lat  = c_nv + 2;
   localparam int c_lat1 = 3;
`else
   localparam int c_lat  = c_nv + 1;
   localparam int c_lat1 = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fcw_wr_en = 1'b0;
   logic [1:0]  fcw_wr_idx = '0;
   logic [23:0] fcw_wr_data = '0;
   logic [3:0]  voice_en = '0;
   logic        next_sample = 1'b0;
   logic        busy;
   logic [9:0]  code;
   logic        code_valid;

   logic        fcw_wr_en1 = 1'b0;
   logic [0:0]  fcw_wr_idx1 = '0;
   logic [23:0] fcw_wr_data1 = '0;
   logic [0:0]  voice_en1 = '0;
   logic        next_sample1 = 1'b0;
   logic        busy1;
   logic [9:0]  code1;
   logic        code_valid1;

   int n_checks = 0;
   int n_fail   = 0;
   int lut_ref [10] = '{524, 537, 549, 562, 574, 586, 599, 611, 623, 636};
   int exp_seq [4]  = '{639, 512, 384, 512};

   nco_poly dut (
      .clk(clk), .rst(rst), .fcw_wr_en(fcw_wr_en), .fcw_wr_idx(fcw_wr_idx),
      .fcw_wr_data(fcw_wr_data), .voice_en(voice_en), .next_sample(next_sample),
      .busy(busy), .code(code), .code_valid(code_valid)
   );

   nco_poly #(.N_VOICES(1)) dut1 (
      .clk(clk), .rst(rst), .fcw_wr_en(fcw_wr_en1), .fcw_wr_idx(fcw_wr_idx1),
      .fcw_wr_data(fcw_wr_data1), .voice_en(voice_en1), .next_sample(next_sample1),
      .busy(busy1), .code(code1), .code_valid(code_valid1)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wr_fcw(input int idx, input logic [23:0] d);
      fcw_wr_en   = 1'b1;
      fcw_wr_idx  = 2'(idx);
      fcw_wr_data = d;
      tick();
      fcw_wr_en   = 1'b0;
   endtask

   // One request on the 4-voice instance; returns busy-cycle count.
   task automatic sample(input string tag, input int expc, output int bcnt);
      int cyc;
      next_sample = 1'b1;
      tick();
      next_sample = 1'b0;
      cyc  = 0;
      bcnt = 0;
      while (code_valid !== 1'b1 && cyc < 20) begin
         if (busy === 1'b1) bcnt++;
         tick();
         cyc++;
      end
      check({tag, "_code"}, 32'(code), 32'(expc));
      check({tag, "_lat"}, 32'(cyc), 32'(c_lat));
      tick();
      check({tag, "_pulse"}, 32'(code_valid), 32'd0);
   endtask

   task automatic sample1(input string tag, input int expc);
      int cyc;
      next_sample1 = 1'b1;
      tick();
      next_sample1 = 1'b0;
      cyc = 0;
      while (code_valid1 !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, "_code"}, 32'(code1), 32'(expc));
      check({tag, "_lat"}, 32'(cyc), 32'(c_lat1));
   endtask

   initial begin
      int bc;
      int pulses;
      int got [8];

      do_reset();
      check("rst_code", 32'(code), 32'd512);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(code_valid), 32'd0);
      check("rst_code1", 32'(code1), 32'd512);

      // All four voices one LUT step per sample
      for (int v = 0; v < 4; v++) wr_fcw(v, 24'h010000);
      voice_en = 4'hF;
      sample("all4", 524, bc);
      check("all4_busy", 32'(bc), 32'(c_lat));

      // Single quarter-turn voice
      do_reset();
      wr_fcw(0, 24'h400000);
      voice_en = 4'b0001;
      for (int i = 0; i < 5; i++) sample($sformatf("quarter%0d", i), exp_seq[i % 4], bc);

      // Disabled voice keeps its phase
      do_reset();
      wr_fcw(1, 24'h400000);
      voice_en = 4'b0000;
      sample("frz_off", 512, bc);
      voice_en = 4'b0010;
      sample("frz_on0", 639, bc);
      sample("frz_on1", 512, bc);

      // Request held high: busy requests ignored, one pulse per sweep
      do_reset();
      wr_fcw(0, 24'h400000);
      voice_en = 4'b0001;
      pulses = 0;
      next_sample = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (i == 20) next_sample = 1'b0;
         tick();
         if (code_valid === 1'b1) begin
            if (pulses < 8) got[pulses] = int'(code);
            pulses++;
         end
      end
      next_sample = 1'b0;
      check("hold_pulses", 32'(pulses), 32'd4);
      for (int i = 0; i < 4; i++) check($sformatf("hold_code%0d", i), 32'(got[i]), 32'(exp_seq[i]));

      // Reset mid-sweep, colliding with a write and a request
      do_reset();
      wr_fcw(0, 24'h400000);
      voice_en = 4'b0001;
      next_sample = 1'b1;
      tick();
      next_sample = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      fcw_wr_en = 1'b1;
      fcw_wr_idx = 2'd0;
      fcw_wr_data = 24'h400000;
      next_sample = 1'b1;
      tick();
      rst = 1'b0;
      fcw_wr_en = 1'b0;
      next_sample = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_code", 32'(code), 32'd512);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (code_valid === 1'b1) pulses++;
         tick();
      end
      check("abort_pulses", 32'(pulses), 32'd0);
      sample("abort_fcw0", 512, bc);
      wr_fcw(0, 24'h400000);
      sample("abort_restart", 639, bc);

      // Modular phase wrap
      do_reset();
      wr_fcw(0, 24'hC00000);
      voice_en = 4'b0001;
      sample("wrap0", 384, bc);
      sample("wrap1", 512, bc);
      sample("wrap2", 639, bc);
      sample("wrap3", 512, bc);
`ifndef NCO_INTERP_EN
      wr_fcw(0, 24'hFFFFFF);
      sample("wrapff0", 509, bc);
      sample("wrapff1", 509, bc);
      wr_fcw(0, 24'h000002);
      sample("wrapff2", 512, bc);
`endif

      // Single-voice instance walks the LUT
      do_reset();
      fcw_wr_en1   = 1'b1;
      fcw_wr_idx1  = 1'b0;
      fcw_wr_data1 = 24'h010000;
      voice_en1    = 1'b1;
      tick();
      fcw_wr_en1   = 1'b0;
      for (int k = 0; k < 10; k++) sample1($sformatf("lut%0d", k + 1), lut_ref[k]);

`ifdef NCO_INTERP_EN
      do_reset();
      fcw_wr_en1   = 1'b1;
      fcw_wr_data1 = 24'h001000;
      tick();
      fcw_wr_en1   = 1'b0;
      for (int f = 1; f <= 16; f++) sample1($sformatf("interp%0d", f), 512 + (12 * f) / 16);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
